pipe_ctrl_unit: RTL

//  Pipelined control/hazard unit for the 16-bit MIPS datapath. Decodes the ID-stage opcode into the 11-bit control word
//  and carries it, with destination/source reg ids, through ID/EX, EX/MEM and MEM/WB registers. Adds load-use stall,

---
 rtl/pipe_ctrl_unit_pkg.sv | 34 +++
 rtl/pipe_ctrl_unit_if.sv | 40 ++++
 rtl/pipe_ctrl_unit_decode.sv | 40 ++++
 rtl/pipe_ctrl_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared control-word layout, opcode map and forwarding encodings for the
// 16-bit MIPS pipeline control unit.
package mips_ctrl_pkg;

  localparam int CTLW = 11;

  localparam int CTL_JUMP     = 10;
  localparam int CTL_REGWRITE = 9;
  localparam int CTL_ALUSRC   = 8;
  localparam int CTL_MEMWRITE = 7;
  localparam int CTL_ALUOP_HI = 6;
  localparam int CTL_ALUOP_LO = 4;
  localparam int CTL_MEMTOREG = 3;
  localparam int CTL_MEMREAD  = 2;
  localparam int CTL_BRANCH   = 1;
  localparam int CTL_REGDEST  = 0;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_J   = 4'd12;
  localparam logic [3:0] OP_BNE = 4'd14;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef logic [CTLW-1:0] ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Datapath <-> control-unit bundle: ID-stage instruction fields and EX/memory
// status in, per-stage control words, hazard and forwarding controls out.
interface pipe_ctrl_unit_if #(
  parameter int OPW  = 4,
  parameter int REGW = 3
);
  import mips_ctrl_pkg::*;

  logic            id_valid;
  logic [OPW-1:0]  id_opcode;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic [REGW-1:0] id_rd;
  logic            ex_br_taken;
  logic            mem_wait;

  ctrl_t           ex_ctrl;
  ctrl_t           mem_ctrl;
  ctrl_t           wb_ctrl;
  logic [REGW-1:0] ex_dst;
  logic [REGW-1:0] mem_dst;
  logic [REGW-1:0] wb_dst;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            stall;
  logic            flush_ifid;
  logic            illegal_op;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_br_taken, mem_wait,
    input  ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst,
    input  fwd_a, fwd_b, stall, flush_ifid, illegal_op
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_br_taken, mem_wait,
    output ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst,
    output fwd_a, fwd_b, stall, flush_ifid, illegal_op
  );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational opcode decoder: ID opcode -> 11-bit control word, with an
// illegal flag for valid instructions outside the opcode map.
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           id_valid,
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl,
  output logic           illegal
);

  ctrl_t table_ctrl;
  logic  in_map;
  logic  high_bits;

  assign high_bits = (opcode >> 4) != '0;

  always_comb begin
    table_ctrl = '0;
    in_map     = 1'b1;
    case (opcode[3:0])
      OP_AND:  table_ctrl = 11'b010_0010_0001;
      OP_OR:   table_ctrl = 11'b010_0011_0001;
      OP_ADD:  table_ctrl = 11'b010_0000_0001;
      OP_SUB:  table_ctrl = 11'b010_0001_0001;
      OP_SLT:  table_ctrl = 11'b010_0100_0001;
      OP_LW:   table_ctrl = 11'b011_0000_1100;
      OP_SW:   table_ctrl = 11'b001_1000_0000;
      OP_BNE:  table_ctrl = 11'b000_0101_0010;
      OP_J:    table_ctrl = 11'b100_0000_0000;
      default: in_map     = 1'b0;
    endcase
  end

  assign ctrl    = (id_valid && in_map && !high_bits) ? table_ctrl : '0;
  assign illegal = id_valid && !(in_map && !high_bits);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control/hazard unit: carries decoded control through ID/EX,
// EX/MEM and MEM/WB and generates stall, flush and EX forwarding selects.
module pipe_ctrl_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int REGW   = 3,
  parameter bit FWD_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  pipe_ctrl_unit_if.slave bus
);

  ctrl_t           dec_ctrl;
  logic            dec_ill;
  logic            use_rs, use_rt;
  logic [REGW-1:0] dec_dst;

  ctrl_t           ctrl_p0, ctrl_p1, ctrl_p2;
  logic [REGW-1:0] dst_p0, dst_p1, dst_p2;
  logic [REGW-1:0] rs_p0, rt_p0;
  logic            vld_p0, vld_p1, vld_p2;
  logic            ill_p0;

  logic load_use, raw_ex, raw_mem, hazard, br_flush, jmp_flush, stall_i, bubble;

  ctrl_decode #(.OPW(OPW)) u_dec (
    .id_valid (bus.id_valid),
    .opcode   (bus.id_opcode),
    .ctrl     (dec_ctrl),
    .illegal  (dec_ill)
  );

  assign use_rs  = (dec_ctrl != '0) && !dec_ctrl[CTL_JUMP];
  assign use_rt  = dec_ctrl[CTL_REGDEST] || dec_ctrl[CTL_MEMWRITE] || dec_ctrl[CTL_BRANCH];
  assign dec_dst = !dec_ctrl[CTL_REGWRITE] ? '0 :
                   dec_ctrl[CTL_REGDEST] ? bus.id_rd : bus.id_rt;

  function automatic logic src_hit(input logic wr, input logic [REGW-1:0] dst);
    return wr && (dst != '0) &&
           ((use_rs && bus.id_rs == dst) || (use_rt && bus.id_rt == dst));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src);
    if (!FWD_EN)
      return FWD_RF;
    if (vld_p1 && ctrl_p1[CTL_REGWRITE] && dst_p1 != '0 && dst_p1 == src)
      return FWD_MEM;
    if (vld_p2 && ctrl_p2[CTL_REGWRITE] && dst_p2 != '0 && dst_p2 == src)
      return FWD_WB;
    return FWD_RF;
  endfunction

  // WB is never a hazard source: the register file writes before it reads.
  assign load_use  = src_hit(vld_p0 && ctrl_p0[CTL_MEMREAD], dst_p0);
  assign raw_ex    = src_hit(vld_p0 && ctrl_p0[CTL_REGWRITE], dst_p0);
  assign raw_mem   = src_hit(vld_p1 && ctrl_p1[CTL_REGWRITE], dst_p1);
  assign hazard    = load_use || (!FWD_EN && (raw_ex || raw_mem));
  assign br_flush  = vld_p0 && ctrl_p0[CTL_BRANCH] && bus.ex_br_taken && !bus.mem_wait;
  assign stall_i   = bus.mem_wait || (hazard && !br_flush);
  assign jmp_flush = dec_ctrl[CTL_JUMP] && !stall_i && !bus.mem_wait;
  assign bubble    = br_flush || hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_p0 <= '0; ctrl_p1 <= '0; ctrl_p2 <= '0;
      dst_p0  <= '0; dst_p1  <= '0; dst_p2  <= '0;
      rs_p0   <= '0; rt_p0   <= '0;
      vld_p0  <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0;
      ill_p0  <= 1'b0;
    end else if (!bus.mem_wait) begin
      // ID -> ID/EX
      if (bubble) begin
        ctrl_p0 <= '0;
        dst_p0  <= '0;
        rs_p0   <= '0;
        rt_p0   <= '0;
        vld_p0  <= 1'b0;
        ill_p0  <= 1'b0;
      end else begin
        ctrl_p0 <= dec_ctrl;
        dst_p0  <= dec_dst;
        rs_p0   <= use_rs ? bus.id_rs : '0;
        rt_p0   <= use_rt ? bus.id_rt : '0;
        vld_p0  <= dec_ctrl != '0;
        ill_p0  <= dec_ill;
      end
      // ID/EX -> EX/MEM
      ctrl_p1 <= ctrl_p0;
      dst_p1  <= dst_p0;
      vld_p1  <= vld_p0;
      // EX/MEM -> MEM/WB
      ctrl_p2 <= ctrl_p1;
      dst_p2  <= dst_p1;
      vld_p2  <= vld_p1;
    end
  end

  assign bus.ex_ctrl    = ctrl_p0;
  assign bus.mem_ctrl   = ctrl_p1;
  assign bus.wb_ctrl    = ctrl_p2;
  assign bus.ex_dst     = dst_p0;
  assign bus.mem_dst    = dst_p1;
  assign bus.wb_dst     = dst_p2;
  assign bus.fwd_a      = fwd_sel(rs_p0);
  assign bus.fwd_b      = fwd_sel(rt_p0);
  assign bus.stall      = !rst && stall_i;
  assign bus.flush_ifid = !rst && (br_flush || jmp_flush);
  assign bus.illegal_op = ill_p0;

endmodule
